serial_priority_encoder: RTL and testbench

- Registered, multi-index successor to the combinational priority encoder.
- Captures a request vector through a valid/ready handshake, then emits the binary index of every set bit, one per output handshake, in priority order.
- Supports fixed priority (bit 0 highest) or round-robin priority that rotates past the last emitted index.
- Used where several simultaneous events each need service, e.g. multiple ready functional units or pending writeback slots.

---
 rtl/serial_priority_encoder_if.sv | 23 ++
 rtl/serial_priority_encoder.sv | 56 +++++
 tb/tb_serial_priority_encoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_priority_encoder_if.sv
// serial_priority_encoder_if: capture and index handshakes of the serial priority encoder
interface serial_priority_encoder_if #(
  parameter int NUM_WIRE = 16
);
  localparam int IW = $clog2(NUM_WIRE);
  localparam int CW = $clog2(NUM_WIRE + 1);
  logic [NUM_WIRE-1:0] wire_in_i;
  logic                wire_valid_i;
  logic                wire_ready_o;
  logic [IW-1:0]       index_o;
  logic                index_valid_o;
  logic                index_ready_i;
  logic                last_o;
  logic [CW-1:0]       pending_count_o;
  modport slave (
    input  wire_in_i, wire_valid_i, index_ready_i,
    output wire_ready_o, index_o, index_valid_o, last_o, pending_count_o
  );
  modport master (
    output wire_in_i, wire_valid_i, index_ready_i,
    input  wire_ready_o, index_o, index_valid_o, last_o, pending_count_o
  );
endinterface

// File: rtl/serial_priority_encoder.sv
// serial_priority_encoder: captures a request vector and emits each set bit's index in priority order
module serial_priority_encoder #(
  parameter int NUM_WIRE = 16,
  parameter int RR_MODE  = 0
) (
  input logic clk_i,
  input logic rst_i,
  serial_priority_encoder_if.slave bus
);
  localparam int IW = $clog2(NUM_WIRE);
  localparam int CW = $clog2(NUM_WIRE + 1);
  logic [NUM_WIRE-1:0] pend_q;
  logic [NUM_WIRE-1:0] clear_mask;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       ptr_nxt;
  logic [CW-1:0]       cnt;
  logic                take;
  logic                cap;
  // search upward from ptr_q with wrap; scanning from the far end lets the nearest hit win
  always_comb begin
    int p;
    p = 0;
    idx = '0;
    for (int k = NUM_WIRE - 1; k >= 0; k--) begin
      p = int'(ptr_q) + k;
      p = (p >= NUM_WIRE) ? p - NUM_WIRE : p;
      idx = pend_q[p] ? IW'(p) : idx;
    end
  end
  // number of bits still waiting to be emitted
  always_comb begin
    cnt = '0;
    for (int k = 0; k < NUM_WIRE; k++) cnt = cnt + CW'(pend_q[k]);
  end
  assign take                = bus.index_valid_o && bus.index_ready_i;
  assign cap                 = bus.wire_valid_i && bus.wire_ready_o;
  assign clear_mask          = {{(NUM_WIRE-1){1'b0}}, 1'b1} << idx;
  assign ptr_nxt             = (int'(idx) == NUM_WIRE - 1) ? '0 : idx + 1'b1;
  assign bus.index_o         = idx;
  assign bus.index_valid_o   = |pend_q;
  assign bus.last_o          = cnt == CW'(1);
  assign bus.pending_count_o = cnt;
  assign bus.wire_ready_o    = ~|pend_q || (take && bus.last_o);
  // capture wins over clearing the final bit so back-to-back vectors have no bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      ptr_q  <= '0;
    end else begin
      if (cap) pend_q <= bus.wire_in_i;
      else if (take) pend_q <= pend_q & ~clear_mask;
      if (RR_MODE != 0 && take) ptr_q <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_serial_priority_encoder.sv
// tb_serial_priority_encoder: directed and random checks of three encoder configurations against a reference model
module tb_serial_priority_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int n [3]  = '{16, 16, 5};
  int rr [3] = '{0, 1, 1};
  logic [15:0] w_in [3];
  logic        w_valid [3];
  logic        i_ready [3];
  logic [3:0]  o_idx [3];
  logic [4:0]  o_cnt [3];
  logic        o_val [3];
  logic        o_rdy [3];
  logic        o_last [3];
  logic [15:0] m_pend [3];
  int          m_ptr [3];
  int em0[$], em1[$], em2[$], exp_q[$];
  int checks = 0;
  int errors = 0;
  bit chk_en;
  serial_priority_encoder_if #(.NUM_WIRE(16)) sif0 ();
  serial_priority_encoder_if #(.NUM_WIRE(16)) sif1 ();
  serial_priority_encoder_if #(.NUM_WIRE(5))  sif2 ();
  serial_priority_encoder #(.NUM_WIRE(16), .RR_MODE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(sif0));
  serial_priority_encoder #(.NUM_WIRE(16), .RR_MODE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(sif1));
  serial_priority_encoder #(.NUM_WIRE(5),  .RR_MODE(1)) dut2 (.clk_i(clk), .rst_i(rst), .bus(sif2));
  assign sif0.wire_in_i = w_in[0];
  assign sif1.wire_in_i = w_in[1];
  assign sif2.wire_in_i = w_in[2][4:0];
  assign sif0.wire_valid_i = w_valid[0];
  assign sif1.wire_valid_i = w_valid[1];
  assign sif2.wire_valid_i = w_valid[2];
  assign sif0.index_ready_i = i_ready[0];
  assign sif1.index_ready_i = i_ready[1];
  assign sif2.index_ready_i = i_ready[2];
  assign o_idx[0] = sif0.index_o;
  assign o_idx[1] = sif1.index_o;
  assign o_idx[2] = {1'b0, sif2.index_o};
  assign o_cnt[0] = sif0.pending_count_o;
  assign o_cnt[1] = sif1.pending_count_o;
  assign o_cnt[2] = {2'b00, sif2.pending_count_o};
  assign o_val[0] = sif0.index_valid_o;
  assign o_val[1] = sif1.index_valid_o;
  assign o_val[2] = sif2.index_valid_o;
  assign o_rdy[0] = sif0.wire_ready_o;
  assign o_rdy[1] = sif1.wire_ready_o;
  assign o_rdy[2] = sif2.wire_ready_o;
  assign o_last[0] = sif0.last_o;
  assign o_last[1] = sif1.last_o;
  assign o_last[2] = sif2.last_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // first set bit at or after the pointer, going round the ring of n[d] positions
  function automatic int m_index(int d);
    for (int k = 0; k < n[d]; k++) begin
      int p = (m_ptr[d] + k) % n[d];
      if (m_pend[d][p]) return p;
    end
    return 0;
  endfunction

  task automatic m_step(int d);
    int idx = m_index(d);
    int c = $countones(m_pend[d]);
    bit take = (m_pend[d] != 0) && i_ready[d];
    bit cap = w_valid[d] && (m_pend[d] == 0 || (take && c == 1));
    logic [15:0] mask = 16'((32'd1 << n[d]) - 1);
    if (rst) begin
      m_pend[d] = '0;
      m_ptr[d] = 0;
    end else begin
      if (take) m_pend[d][idx] = 1'b0;
      if (cap) m_pend[d] = w_in[d] & mask;
      if (take && rr[d] != 0) m_ptr[d] = (idx + 1) % n[d];
    end
  endtask

  task automatic tick();
    #1;
    for (int d = 0; d < 3; d++) begin
      int c = $countones(m_pend[d]);
      if (chk_en) begin
        chk($sformatf("d%0d valid", d), 32'(o_val[d]), 32'(m_pend[d] != 0));
        chk($sformatf("d%0d index", d), 32'(o_idx[d]), 32'(m_index(d)));
        chk($sformatf("d%0d count", d), 32'(o_cnt[d]), 32'(c));
        chk($sformatf("d%0d last", d), 32'(o_last[d]), 32'(c == 1));
        chk($sformatf("d%0d ready", d), 32'(o_rdy[d]), 32'(m_pend[d] == 0 || (i_ready[d] && c == 1)));
      end
      if (!rst && o_val[d] === 1'b1 && i_ready[d]) begin
        if (d == 0) em0.push_back(int'(o_idx[d]));
        else if (d == 1) em1.push_back(int'(o_idx[d]));
        else em2.push_back(int'(o_idx[d]));
      end
      m_step(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) begin
      w_in[d] = '0;
      w_valid[d] = 1'b0;
      i_ready[d] = 1'b1;
    end
  endtask

  task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
    chk({tag, " len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = '0;
      m_ptr[d] = 0;
      w_in[d] = 16'hFFFF;
      w_valid[d] = 1'b1;
      i_ready[d] = 1'b1;
    end
    rst = 1'b1;
    chk_en = 1'b0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk("rst ready", 32'(o_rdy[0]), 32'd1);
    chk("rst valid", 32'(o_val[0]), 32'd0);
    chk("rst count", 32'(o_cnt[0]), 32'd0);
    chk("rst index", 32'(o_idx[0]), 32'd0);
    chk("rst last", 32'(o_last[0]), 32'd0);
    em0.delete();
    w_in[0] = 16'b1000_0100_0001_0000;
    w_valid[0] = 1'b1;
    tick();
    w_valid[0] = 1'b0;
    chk("fixed first count", 32'(o_cnt[0]), 32'd3);
    repeat (4) tick();
    exp_q = '{4, 10, 15};
    chk_seq("fixed drain", em0, exp_q);
    em0.delete();
    w_in[0] = 16'h0003;
    w_valid[0] = 1'b1;
    tick();
    w_valid[0] = 1'b0;
    i_ready[0] = 1'b0;
    repeat (3) tick();
    chk("stall index", 32'(o_idx[0]), 32'd0);
    chk("stall ready", 32'(o_rdy[0]), 32'd0);
    i_ready[0] = 1'b1;
    tick();
    w_in[0] = 16'h0100;
    w_valid[0] = 1'b1;
    #1;
    chk("b2b ready", 32'(o_rdy[0]), 32'd1);
    tick();
    w_valid[0] = 1'b0;
    repeat (2) tick();
    exp_q = '{0, 1, 8};
    chk_seq("back to back", em0, exp_q);
    em1.delete();
    w_in[1] = 16'h8001;
    w_valid[1] = 1'b1;
    tick();
    w_valid[1] = 1'b0;
    repeat (2) tick();
    w_in[1] = 16'h8003;
    w_valid[1] = 1'b1;
    tick();
    w_valid[1] = 1'b0;
    repeat (3) tick();
    w_in[1] = 16'h0002;
    w_valid[1] = 1'b1;
    tick();
    w_in[1] = 16'h0006;
    tick();
    w_valid[1] = 1'b0;
    repeat (3) tick();
    exp_q = '{0, 15, 0, 1, 15, 1, 2, 1};
    chk_seq("round robin", em1, exp_q);
    em0.delete();
    w_in[0] = 16'h0000;
    w_valid[0] = 1'b1;
    tick();
    w_valid[0] = 1'b0;
    tick();
    chk("zero valid", 32'(o_val[0]), 32'd0);
    chk("zero ready", 32'(o_rdy[0]), 32'd1);
    w_in[0] = 16'h00F0;
    w_valid[0] = 1'b1;
    tick();
    w_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst valid", 32'(o_val[0]), 32'd0);
    chk("mid rst count", 32'(o_cnt[0]), 32'd0);
    repeat (2) tick();
    exp_q = '{4};
    chk_seq("reset mid drain", em0, exp_q);
    em2.delete();
    repeat (2) begin
      w_in[2] = 16'h0011;
      w_valid[2] = 1'b1;
      tick();
      w_valid[2] = 1'b0;
      repeat (2) tick();
    end
    tick();
    exp_q = '{0, 4, 0, 4};
    chk_seq("five wire", em2, exp_q);
    repeat (400) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int d = 0; d < 3; d++) begin
        w_valid[d] = $urandom_range(0, 1) == 1;
        w_in[d] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
        i_ready[d] = $urandom_range(0, 3) != 0;
      end
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
